// File: rtl/ann_pkg.sv
// Shared constants and types for the ANN output path: activation format,
// class count and the serializer state encoding.
package ann_pkg;

    localparam int ACT_W     = 8;
    localparam int N_CLASSES = 10;
    localparam int CLS_W     = 4;

    localparam logic signed [ACT_W-1:0] ACT_MAX = 8'sd127;

    typedef logic [1:0] ser_state_t;

    localparam ser_state_t IDLE = 2'd0;
    localparam ser_state_t SEND = 2'd1;
    localparam ser_state_t PUB  = 2'd2;

endpackage

// File: rtl/layer_out_serializer_argmax_tracker.sv
// Running signed maximum over a stream of (value, index) pairs. The first
// enabled sample after clear always seeds the max; later ties keep the earlier index.
module argmax_tracker
    import ann_pkg::*;
#(
    parameter int DW = ACT_W,
    parameter int CW = CLS_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [DW-1:0] value_i,
    input  logic [CW-1:0] idx_i,
    output logic [DW-1:0] max_val_o,
    output logic [CW-1:0] max_idx_o
);

    logic          seeded_q, seeded_d;
    logic [DW-1:0] max_val_q, max_val_d;
    logic [CW-1:0] max_idx_q, max_idx_d;
    logic          take;

    assign take = en_i && (!seeded_q || ($signed(value_i) > $signed(max_val_q)));

    always_comb begin
        seeded_d  = seeded_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (clear_i) begin
            seeded_d  = 1'b0;
            max_val_d = '0;
            max_idx_d = '0;
        end else if (take) begin
            seeded_d  = 1'b1;
            max_val_d = value_i;
            max_idx_d = idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seeded_q  <= 1'b0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            seeded_q  <= seeded_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_val_o = max_val_q;
    assign max_idx_o = max_idx_q;

endmodule

// File: rtl/layer_out_serializer.sv
// Captures a frame of parallel activations, streams it lane by lane over a
// valid/ready interface and publishes the frame's argmax and saturation count.
module layer_out_serializer
    import ann_pkg::*;
#(
    parameter int N_IN = N_CLASSES,
    parameter int DW   = ACT_W,
    parameter int CW   = CLS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN*DW-1:0] act_flat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_idx,
    output logic               out_first,
    output logic               out_last,
    output logic               argmax_valid,
    output logic [CW-1:0]      argmax_idx,
    output logic [DW-1:0]      argmax_val,
    output logic [CW-1:0]      sat_cnt
);

    localparam logic [CW-1:0] LAST_LANE = CW'(N_IN - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [DW-1:0] SAT_VAL   = {1'b0, {(DW-1){1'b1}}};

    ser_state_t              state_q, state_d;
    logic [N_IN-1:0][DW-1:0] frame_q, frame_d;
    logic [CW-1:0]           lane_q, lane_d;
    logic [CW-1:0]           sat_run_q, sat_run_d;
    logic [CW-1:0]           sat_cnt_q, sat_cnt_d;
    logic [CW-1:0]           argmax_idx_q, argmax_idx_d;
    logic [DW-1:0]           argmax_val_q, argmax_val_d;

    logic [DW-1:0] cur_val;
    logic          beat_xfer;
    logic          trk_clear, trk_en;
    logic [DW-1:0] trk_val;
    logic [CW-1:0] trk_idx;

    assign cur_val   = frame_q[lane_q];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SEND);
    assign beat_xfer = out_valid && out_ready;

    argmax_tracker #(
        .DW(DW),
        .CW(CW)
    ) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (trk_clear),
        .en_i     (trk_en),
        .value_i  (cur_val),
        .idx_i    (lane_q),
        .max_val_o(trk_val),
        .max_idx_o(trk_idx)
    );

    // The tracker already includes the last lane during PUB, so the held result registers load there.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        lane_d       = lane_q;
        sat_run_d    = sat_run_q;
        sat_cnt_d    = sat_cnt_q;
        argmax_idx_d = argmax_idx_q;
        argmax_val_d = argmax_val_q;
        trk_clear    = 1'b0;
        trk_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    frame_d   = act_flat;
                    lane_d    = '0;
                    sat_run_d = '0;
                    trk_clear = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (beat_xfer) begin
                    trk_en = 1'b1;
                    if (cur_val == SAT_VAL) begin
                        sat_run_d = sat_run_q + ONE;
                    end
                    if (lane_q == LAST_LANE) begin
                        lane_d  = '0;
                        state_d = PUB;
                    end else begin
                        lane_d = lane_q + ONE;
                    end
                end
            end
            PUB: begin
                argmax_idx_d = trk_idx;
                argmax_val_d = trk_val;
                sat_cnt_d    = sat_run_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            lane_q       <= '0;
            sat_run_q    <= '0;
            sat_cnt_q    <= '0;
            argmax_idx_q <= '0;
            argmax_val_q <= '0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            lane_q       <= lane_d;
            sat_run_q    <= sat_run_d;
            sat_cnt_q    <= sat_cnt_d;
            argmax_idx_q <= argmax_idx_d;
            argmax_val_q <= argmax_val_d;
        end
    end

    assign out_data     = cur_val;
    assign out_idx      = lane_q;
    assign out_first    = out_valid && (lane_q == '0);
    assign out_last     = out_valid && (lane_q == LAST_LANE);
    assign argmax_valid = (state_q == PUB);
    assign argmax_idx   = argmax_valid ? trk_idx   : argmax_idx_q;
    assign argmax_val   = argmax_valid ? trk_val   : argmax_val_q;
    assign sat_cnt      = argmax_valid ? sat_run_q : sat_cnt_q;

endmodule
